reorder_ctrl: RTL and testbench

REORDER_CTRL -- requirements
Module: reorder_ctrl

---
 rtl/reorder_pkg.sv | 37 +++
 rtl/reorder_bank_fsm.sv | 50 +++++
 rtl/reorder_ctrl.sv | 112 +++++++++++
 tb/tb_reorder_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reorder_pkg.sv
// Shared constants, bank state type and bit-reversal helpers for the
// 512-point frame reorder controller.
package reorder_pkg;

    localparam int unsigned N_PT  = 512;
    localparam int unsigned LANES = 32;
    localparam int unsigned BEATS = 16;

    typedef enum logic [1:0] {
        BankEmpty    = 2'd0,
        BankFilling  = 2'd1,
        BankFull     = 2'd2,
        BankDraining = 2'd3
    } bank_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = v[3-i];
        end
        return r;
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = v[4-i];
        end
        return r;
    endfunction

    // Source sample index for a lane and column: bitrev5(lane) * 16 + col.
    function automatic logic [8:0] src_index(input logic [4:0] lane, input logic [3:0] col);
        return {bitrev5(lane), col};
    endfunction

endpackage

// File: rtl/reorder_bank_fsm.sv
// Occupancy state machine for one ping-pong bank: EMPTY -> FILLING -> FULL
// -> DRAINING -> EMPTY, driven by accepted write and read beats.
module reorder_bank_fsm
    import reorder_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic wr_acc,
    input  logic wr_last,
    input  logic rd_acc,
    input  logic rd_last,
    output logic can_write,
    output logic can_read
);

    bank_state_t state_q, state_d;

    // Next-state: a bank is only ever written or read, never both at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BankEmpty: begin
                if (wr_acc) state_d = wr_last ? BankFull : BankFilling;
            end
            BankFilling: begin
                if (wr_acc && wr_last) state_d = BankFull;
            end
            BankFull: begin
                if (rd_acc) state_d = rd_last ? BankEmpty : BankDraining;
            end
            BankDraining: begin
                if (rd_acc && rd_last) state_d = BankEmpty;
            end
            default: state_d = BankEmpty;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= BankEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    assign can_write = (state_q == BankEmpty) || (state_q == BankFilling);
    assign can_read  = (state_q == BankFull) || (state_q == BankDraining);

endmodule

// File: rtl/reorder_ctrl.sv
// Ping-pong reorder controller: fills one bank in natural beat order while
// draining the other in bit-reversed column order (rd_col = bitrev4(rd_beat)).
module reorder_ctrl #(
    parameter int unsigned LANES = reorder_pkg::LANES,
    parameter int unsigned BEATS = reorder_pkg::BEATS
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       wr_en,
    output logic       wr_bank,
    output logic [3:0] wr_beat,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       rd_bank,
    output logic [3:0] rd_beat,
    output logic [3:0] rd_col,
    output logic       out_sof,
    output logic       out_eof,
    output logic       frame_done,
    output logic       ovf_err
);
    import reorder_pkg::*;

    if (LANES * BEATS != N_PT || BEATS > 16 || BEATS < 1) begin : g_bad_cfg
        $error("reorder_ctrl: LANES * BEATS must equal N_PT with BEATS in 1..16");
    end

    localparam logic [3:0] LastBeat = 4'(BEATS - 1);

    logic       wr_ptr_q, rd_ptr_q;
    logic [3:0] wr_cnt_q, rd_cnt_q;
    logic       frame_done_q, ovf_q;
    logic [1:0] can_write, can_read;
    logic       wr_acc, rd_acc, wr_last, rd_last;

    // Reset forces the idle handshake regardless of the state being cleared.
    assign in_ready  = rstn | can_write[wr_ptr_q];
    assign wr_en     = in_valid & in_ready & ~rstn;
    assign out_valid = ~rstn & can_read[rd_ptr_q];

    assign wr_acc  = wr_en;
    assign rd_acc  = out_valid & out_ready;
    assign wr_last = (wr_cnt_q == LastBeat);
    assign rd_last = (rd_cnt_q == LastBeat);

    for (genvar i = 0; i < 2; i++) begin : g_bank
        reorder_bank_fsm u_fsm (
            .clk       (clk),
            .rstn      (rstn),
            .wr_acc    (wr_acc & (wr_ptr_q == 1'(i))),
            .wr_last   (wr_last),
            .rd_acc    (rd_acc & (rd_ptr_q == 1'(i))),
            .rd_last   (rd_last),
            .can_write (can_write[i]),
            .can_read  (can_read[i])
        );
    end

    // Write side: beat counter and bank pointer advance on accepted beats.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_cnt_q <= 4'd0;
            wr_ptr_q <= 1'b0;
        end else if (wr_acc) begin
            if (wr_last) begin
                wr_cnt_q <= 4'd0;
                wr_ptr_q <= ~wr_ptr_q;
            end else begin
                wr_cnt_q <= wr_cnt_q + 4'd1;
            end
        end
    end

    // Read side: beat counter and bank pointer advance on accepted outputs.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rd_cnt_q <= 4'd0;
            rd_ptr_q <= 1'b0;
        end else if (rd_acc) begin
            if (rd_last) begin
                rd_cnt_q <= 4'd0;
                rd_ptr_q <= ~rd_ptr_q;
            end else begin
                rd_cnt_q <= rd_cnt_q + 4'd1;
            end
        end
    end

    // Status: one-cycle frame_done pulse and sticky overflow on dropped beats.
    always_ff @(posedge clk) begin
        if (rstn) begin
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            frame_done_q <= rd_acc & rd_last;
            if (in_valid && !in_ready) ovf_q <= 1'b1;
        end
    end

    assign wr_bank    = wr_ptr_q;
    assign wr_beat    = wr_cnt_q;
    assign rd_bank    = rd_ptr_q;
    assign rd_beat    = rd_cnt_q;
    assign rd_col     = bitrev4(rd_cnt_q);
    assign out_sof    = out_valid & (rd_cnt_q == 4'd0);
    assign out_eof    = out_valid & rd_last;
    assign frame_done = frame_done_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_reorder_ctrl.sv
// Scoreboard bench for reorder_ctrl: a frame-level model predicts handshakes
// and pushes the expected reordered beats; a monitor pops them on each output.
module tb_reorder_ctrl;

    localparam int BEATS = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, wr_en, wr_bank, out_valid, rd_bank;
    logic       out_sof, out_eof, frame_done, ovf_err;
    logic [3:0] wr_beat, rd_beat, rd_col;

    always #5 clk = ~clk;

    reorder_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_beat    (wr_beat),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .rd_bank    (rd_bank),
        .rd_beat    (rd_beat),
        .rd_col     (rd_col),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .frame_done (frame_done),
        .ovf_err    (ovf_err)
    );

    typedef struct {
        int bank;
        int beat;
        int col;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Frame-level model: completed-but-undrained frames, fill and drain progress.
    int pend = 0;
    int fill = 0;
    int didx = 0;
    int fin = 0;
    int fout = 0;
    int fd_exp = 0;
    int ovf_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int brev4(input int b);
        return ((b % 2) * 8) + (((b / 2) % 2) * 4) + (((b / 4) % 2) * 2) + ((b / 8) % 2);
    endfunction

    // One clock cycle: drive inputs, check combinational/registered outputs,
    // then advance the model to match the coming edge.
    task automatic step(input bit iv, input bit ordy, input bit rst, input bit do_chk);
        bit room;
        bit aw;
        bit ar;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        rstn      = rst;
        #1;
        room = (pend < 2);
        if (do_chk) begin
            chk("frame_done", frame_done, fd_exp);
            chk("ovf_err", ovf_err, ovf_exp);
            chk("in_ready", in_ready, rst ? 1 : int'(room));
            chk("out_valid", out_valid, int'(!rst && pend > 0));
            chk("wr_en", wr_en, int'(!rst && iv && room));
            if (!rst && iv && room) begin
                chk("wr_beat", wr_beat, fill);
                chk("wr_bank", wr_bank, fin % 2);
            end
        end
        if (rst) begin
            pend = 0; fill = 0; didx = 0; fin = 0; fout = 0;
            fd_exp = 0; ovf_exp = 0;
            sb.delete();
        end else begin
            aw = iv && room;
            ar = ordy && (pend > 0);
            fd_exp = int'(ar && didx == BEATS - 1);
            if (iv && !room) ovf_exp = 1;
            if (ar) begin
                didx++;
                if (didx == BEATS) begin
                    didx = 0;
                    pend--;
                    fout++;
                end
            end
            if (aw) begin
                fill++;
                if (fill == BEATS) begin
                    fill = 0;
                    for (int b = 0; b < BEATS; b++) begin
                        sb.push_back('{bank: fin % 2, beat: b, col: brev4(b)});
                    end
                    pend++;
                    fin++;
                end
            end
        end
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: output beat rd_beat=%0d with none expected", rd_beat);
                end else begin
                    e = sb.pop_front();
                    chk("rd_bank", rd_bank, e.bank);
                    chk("rd_beat", rd_beat, e.beat);
                    chk("rd_col", rd_col, e.col);
                    chk("out_sof", out_sof, int'(e.beat == 0));
                    chk("out_eof", out_eof, int'(e.beat == BEATS - 1));
                end
            end
        end
    end

    initial begin
        // Reset with in_valid high: handshake must stay idle and no overflow.
        step(1, 1, 1, 0);
        step(1, 0, 1, 1);

        // Single frame fill then drain at full rate.
        for (int i = 0; i < 16; i++) step(1, 1, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 1);

        // Backpressure: two banks fill, 33rd beat overflows.
        for (int i = 0; i < 33; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 70; i++) step(0, (i % 2) == 0, 0, 1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);

        // Streaming four frames back to back.
        for (int i = 0; i < 64; i++) step(1, 1, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 1);

        // Randomized traffic with one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, i == 750, 1);
        end
        for (int i = 0; i < 40; i++) step(0, 1, 0, 1);

        // Reset after seven beats of a partial frame.
        step(0, 0, 1, 1);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1);
        step(1, 1, 1, 1);
        for (int i = 0; i < 16; i++) step(1, 1, 0, 1);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 1);

        @(negedge clk);
        #3;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
